// File: rtl/jp_pkg.sv
// Joypad constants shared between the console-side controller and this pad emulator,
// plus the turbo gating rule that turns raw buttons into the bits a frame reports.
package jp_pkg;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int JP_FRAME_BITS = 8;

    localparam int               SHIFT_CNT_W   = 4;
    localparam logic [SHIFT_CNT_W-1:0] SHIFT_CNT_FULL = SHIFT_CNT_W'(JP_FRAME_BITS);
    localparam logic [SHIFT_CNT_W-1:0] SHIFT_CNT_SAT  = SHIFT_CNT_W'(JP_FRAME_BITS + 1);

    // A turbo-enabled button only reads pressed during the "on" turbo phase.
    function automatic logic [JP_FRAME_BITS-1:0] jp_effective(
        input logic [JP_FRAME_BITS-1:0] buttons,
        input logic [1:0]               turbo_en,
        input logic                     turbo_phase
    );
        logic [JP_FRAME_BITS-1:0] eff;
        eff        = buttons;
        eff[BTN_A] = buttons[BTN_A] & (~turbo_en[0] | turbo_phase);
        eff[BTN_B] = buttons[BTN_B] & (~turbo_en[1] | turbo_phase);
        return eff;
    endfunction

endpackage

// File: rtl/jp_sync_edge.sv
// Multi-flop synchronizer for an asynchronous controller-port pin, with registered
// level and rise/fall strobes that are all aligned to the same cycle.
module jp_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              level_q, level_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    always_comb begin
        sync_d  = {sync_q[STAGES-2:0], pin_i};
        level_d = sync_q[STAGES-1];
        rise_d  = sync_q[STAGES-1] & ~level_q;
        fall_d  = ~sync_q[STAGES-1] & level_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/jp_pad_emu.sv
// Device-side NES joypad: a 4021-style parallel-in/serial-out register driven by the
// console's latch and shift clock, with A/B turbo and poll/overread statistics.
module jp_pad_emu
    import jp_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TURBO_DIV   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  buttons,
    input  logic [1:0]  turbo_en,
    input  logic        jp_latch,
    input  logic        jp_clk,
    output logic        jp_data,
    output logic [15:0] poll_count,
    output logic        overread
);

    localparam int TURBO_CNT_W = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
    localparam logic [TURBO_CNT_W-1:0] TURBO_LAST = TURBO_CNT_W'(TURBO_DIV - 1);

    logic lat_level, lat_rise, lat_fall;
    logic clk_level, clk_rise, clk_fall;
    logic unused_edges;

    logic [JP_FRAME_BITS-1:0] sr_q, sr_d;
    logic [SHIFT_CNT_W-1:0]   shift_cnt_q, shift_cnt_d;
    logic [15:0]              poll_count_q, poll_count_d;
    logic [TURBO_CNT_W-1:0]   turbo_cnt_q, turbo_cnt_d;
    logic                     turbo_phase_q, turbo_phase_d;
    logic                     overread_q, overread_d;
    logic                     data_q, data_d;
    logic [JP_FRAME_BITS-1:0] eff;

    jp_sync_edge #(.STAGES(SYNC_STAGES)) u_latch_sync (
        .clk     (clk),
        .rst     (rst),
        .pin_i   (jp_latch),
        .level_o (lat_level),
        .rise_o  (lat_rise),
        .fall_o  (lat_fall)
    );

    jp_sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
        .clk     (clk),
        .rst     (rst),
        .pin_i   (jp_clk),
        .level_o (clk_level),
        .rise_o  (clk_rise),
        .fall_o  (clk_fall)
    );

    assign unused_edges = ^{lat_rise, clk_level, clk_fall};

    // Latch level beats latch fall beats shift clock; a clock edge colliding with
    // either latch condition is dropped so bit 0 is never skipped.
    always_comb begin
        eff           = jp_effective(buttons, turbo_en, turbo_phase_q);
        sr_d          = sr_q;
        shift_cnt_d   = shift_cnt_q;
        poll_count_d  = poll_count_q;
        turbo_cnt_d   = turbo_cnt_q;
        turbo_phase_d = turbo_phase_q;
        overread_d    = 1'b0;

        if (lat_level) begin
            sr_d        = eff;
            shift_cnt_d = '0;
        end else if (lat_fall) begin
            poll_count_d = poll_count_q + 16'd1;
            if (turbo_cnt_q == TURBO_LAST) begin
                turbo_cnt_d   = '0;
                turbo_phase_d = ~turbo_phase_q;
            end else begin
                turbo_cnt_d = turbo_cnt_q + TURBO_CNT_W'(1);
            end
        end else if (clk_rise) begin
            sr_d       = {1'b1, sr_q[JP_FRAME_BITS-1:1]};
            overread_d = (shift_cnt_q >= SHIFT_CNT_FULL);
            if (shift_cnt_q != SHIFT_CNT_SAT) begin
                shift_cnt_d = shift_cnt_q + SHIFT_CNT_W'(1);
            end
        end

        data_d = ~sr_d[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q          <= '0;
            shift_cnt_q   <= '0;
            poll_count_q  <= '0;
            turbo_cnt_q   <= '0;
            turbo_phase_q <= 1'b1;
            overread_q    <= 1'b0;
            data_q        <= 1'b1;
        end else begin
            sr_q          <= sr_d;
            shift_cnt_q   <= shift_cnt_d;
            poll_count_q  <= poll_count_d;
            turbo_cnt_q   <= turbo_cnt_d;
            turbo_phase_q <= turbo_phase_d;
            overread_q    <= overread_d;
            data_q        <= data_d;
        end
    end

    assign jp_data    = data_q;
    assign poll_count = poll_count_q;
    assign overread   = overread_q;

endmodule

// File: tb/tb_jp_pad_emu.sv
// Randomized console-side driver for jp_pad_emu with a queue-based scoreboard; the
// driver queues expected reads and a separate monitor checks them on each read strobe.
module tb_jp_pad_emu;

    localparam int SYNC = 2;
    localparam int TDIV = 4;
    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  buttons = '0;
    logic [1:0]  turbo_en = '0;
    logic        jp_latch = 1'b0;
    logic        jp_clk = 1'b0;
    logic        jp_data;
    logic [15:0] poll_count;
    logic        overread;

    typedef enum int {K_DATA, K_POLL, K_OVR} kind_e;
    typedef struct {
        kind_e       kind;
        logic [31:0] exp;
        string       name;
    } item_t;

    item_t       expQ[$];
    item_t       curItem;
    logic [31:0] actVal;
    int          compared = 0;
    int          mismatched = 0;
    int          ovrSeen = 0;
    int          ovrExp = 0;
    int          polls = 0;
    logic        strobe = 1'b0;

    jp_pad_emu #(.SYNC_STAGES(SYNC), .TURBO_DIV(TDIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .buttons    (buttons),
        .turbo_en   (turbo_en),
        .jp_latch   (jp_latch),
        .jp_clk     (jp_clk),
        .jp_data    (jp_data),
        .poll_count (poll_count),
        .overread   (overread)
    );

    always #5 clk = ~clk;

    // Monitor: counts overread pulses every cycle and drains the scoreboard on a read strobe.
    always @(posedge clk) begin
        #2;
        if (overread !== 1'b0) ovrSeen++;
        if (strobe) begin
            while (expQ.size() > 0) begin
                curItem = expQ.pop_front();
                case (curItem.kind)
                    K_DATA:  actVal = {31'b0, jp_data};
                    K_POLL:  actVal = {16'b0, poll_count};
                    default: actVal = 32'(ovrSeen);
                endcase
                compared++;
                if (actVal !== curItem.exp) begin
                    mismatched++;
                    $display("[TB] FAIL %s: got %0d, expected %0d", curItem.name, actVal, curItem.exp);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expectItem(input kind_e k, input logic [31:0] v, input string nm);
        item_t it;
        it.kind = k;
        it.exp  = v;
        it.name = nm;
        expQ.push_back(it);
    endtask

    task automatic checkOutput();
        strobe = 1'b1;
        waitCycles(1);
        strobe = 1'b0;
    endtask

    task automatic doReset(input string tag);
        jp_latch = 1'b0;
        jp_clk   = 1'b0;
        rst      = 1'b1;
        waitCycles(2);
        rst      = 1'b0;
        polls    = 0;
        waitCycles(1);
        expectItem(K_DATA, 32'd1, {tag, " data"});
        expectItem(K_POLL, 32'd0, {tag, " poll"});
        expectItem(K_OVR, 32'(ovrExp), {tag, " overread"});
        checkOutput();
    endtask

    // One console poll: latch, optional clocks under latch or coincident with its fall,
    // then nClk shift clocks with a read before each, or a reset after abortAfter shifts.
    task automatic applyStimulus(input logic [7:0] btn, input logic [1:0] ten, input int nClk,
                                 input bit clkInLatch, input bit coincident, input int abortAfter,
                                 input string tag);
        logic [7:0] eff;
        logic       bitExp;
        bit         phaseOn;
        phaseOn = ((polls / TDIV) % 2) == 0;
        eff = btn;
        if (ten[0] && !phaseOn) eff[0] = 1'b0;
        if (ten[1] && !phaseOn) eff[1] = 1'b0;

        buttons  = btn;
        turbo_en = ten;
        jp_latch = 1'b1;
        if (clkInLatch) begin
            repeat (2) begin
                jp_clk = 1'b1;
                waitCycles(HALF);
                jp_clk = 1'b0;
                waitCycles(HALF);
            end
        end else begin
            waitCycles(2 * HALF);
        end

        jp_latch = 1'b0;
        if (coincident) begin
            jp_clk = 1'b1;
            waitCycles(HALF);
            jp_clk = 1'b0;
            waitCycles(HALF);
        end else begin
            waitCycles(2 * HALF);
        end
        polls++;

        bitExp = ~eff[0];
        expectItem(K_DATA, {31'b0, bitExp}, $sformatf("%s bit0", tag));
        expectItem(K_POLL, 32'(polls % 65536), $sformatf("%s poll", tag));
        checkOutput();
        buttons  = 8'($urandom);
        turbo_en = 2'($urandom);

        for (int k = 1; k <= nClk; k++) begin
            jp_clk = 1'b1;
            waitCycles(HALF);
            jp_clk = 1'b0;
            waitCycles(HALF);
            if (k >= 9) ovrExp++;
            if (k == abortAfter) begin
                doReset($sformatf("%s reset", tag));
                return;
            end
            bitExp = (k < 8) ? ~eff[k] : 1'b0;
            expectItem(K_DATA, {31'b0, bitExp}, $sformatf("%s bit%0d", tag, k));
            checkOutput();
        end
        expectItem(K_OVR, 32'(ovrExp), $sformatf("%s overread", tag));
        checkOutput();
        waitCycles(HALF);
    endtask

    initial begin
        waitCycles(1);
        doReset("init");

        applyStimulus(8'b1000_0101, 2'b00, 8, 1'b0, 1'b0, -1, "basic");
        applyStimulus(8'($urandom), 2'b00, 10, 1'b0, 1'b0, -1, "overread");

        doReset("preturbo");
        for (int i = 0; i < 12; i++)
            applyStimulus(8'($urandom) | 8'h01, 2'b01, 1, 1'b0, 1'b0, -1, $sformatf("turboA%0d", i));
        for (int i = 0; i < 6; i++)
            applyStimulus(8'($urandom) | 8'h03, 2'b11, 2, 1'b0, 1'b0, -1, $sformatf("turboAB%0d", i));

        applyStimulus(8'($urandom), 2'b00, 8, 1'b0, 1'b1, -1, "coincident");
        applyStimulus(8'($urandom), 2'b00, 8, 1'b1, 1'b0, -1, "clkInLatch");

        applyStimulus(8'($urandom), 2'b00, 8, 1'b0, 1'b0, 3, "midframe");
        applyStimulus(8'($urandom), 2'b00, 8, 1'b0, 1'b0, -1, "afterReset");

        for (int i = 0; i < 20; i++)
            applyStimulus(8'($urandom), 2'($urandom), int'($urandom_range(0, 11)),
                          1'($urandom), 1'($urandom), -1, $sformatf("rand%0d", i));

        waitCycles(4);
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/jp_pad_emu.md
# jp_pad_emu

Device-side emulation of a standard NES joypad, i.e. the 4021-style parallel-in/serial-out shift register the console-side joypad controller talks to. It sits on the controller-port pins: it receives `jp_latch` and `jp_clk` from a console or host controller, and returns button state serially on `jp_data`. Button state comes from a local source, such as a USB/HID bridge or a test harness. It also provides A/B turbo and simple poll statistics.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth on `jp_latch` and `jp_clk`; legal values are 2 or more.
- `TURBO_DIV`, default 4: number of latch pulses per turbo phase toggle; legal values are 1 or more.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset. Reset rst, synchronous, active-high; clock clk.
- `buttons`, in, 8: pressed = 1. Bit order is A, B, Select, Start, Up, Down, Left, Right, bits 0 to 7. Bit 0 is the first bit presented after latch.
- `turbo_en`, in, 2: bit 0 enables turbo on A; bit 1 enables turbo on B.
- `jp_latch`, in, 1: asynchronous latch from the console, active-high.
- `jp_clk`, in, 1: asynchronous shift clock from the console; the shift action is on its rising edge.
- `jp_data`, out, 1: serial data, active-low (0 = pressed). It comes directly from a register.
- `poll_count`, out, 16: count of latch falling edges; wraps modulo 2^16.
- `overread`, out, 1: one-cycle pulse on each shift clock beyond the 8th since the last latch.

## Operation
**Input synchronization**
- `jp_latch` and `jp_clk` each pass through `SYNC_STAGES` flops.
- Edges are detected by comparing each synced value with its previous synced value. This gives `lat_rise`, `lat_fall` and `clk_rise`.

**Shift register**
- Internal 8-bit shift register `sr`, stored with pressed = 1.
- Output mapping: `jp_data = ~sr[0]`.

**Effective buttons**
- `eff[0] = buttons[0] & (~turbo_en[0] | turbo_phase)`.
- `eff[1]` is formed the same way from `buttons[1]` and `turbo_en[1]`.
- `eff[7:2] = buttons[7:2]`.

**Per-cycle priority, highest first**
1. `rst`: `sr` = 0, `shift_cnt` = 0, `poll_count` = 0, `turbo_cnt` = 0, `turbo_phase` = 1.
2. Synced latch high: `sr` <= `eff` every cycle (transparent parallel load) and `shift_cnt` <= 0. A `clk_rise` in this cycle is ignored.
3. `lat_fall`: `sr` keeps the value loaded in the previous cycle. `poll_count` increments. `turbo_cnt` increments; at `TURBO_DIV-1` it wraps to 0 and `turbo_phase` toggles. A `clk_rise` in the same cycle is ignored.
4. `clk_rise` with latch low:
   - `sr` <= {1'b1, `sr[7:1]`}. Serial-in reads as pressed, so `jp_data` stays 0 after 8 shifts.
   - `shift_cnt` saturates at 9.
   - `overread` = 1 for one cycle if `shift_cnt` was already 8 or more before this edge.
5. Otherwise all state holds.

**Turbo behaviour**
- `turbo_phase` changes only at a latch falling edge.
- A turbo button therefore reads pressed for `TURBO_DIV` polls, then released for `TURBO_DIV` polls.

## Timing
- Reset values: `jp_data` = 1, `poll_count` = 0, `overread` = 0, `turbo_phase` = 1.
- Pin-to-data latency: a pin transition first sampled at clk edge n shows on `jp_data` after edge n+`SYNC_STAGES`+1. With the default this is 3 cycles.
- Input requirement: pin high and low times must each be at least `SYNC_STAGES`+2 clk cycles, otherwise edges may be lost. The console controller in this design uses 32-cycle half-periods.
- Button sampling: `buttons` changes take effect 1 cycle later while latch is high. They are ignored once latch is low.
- Frame reads:
  - After the latch falls, `jp_data` presents `~eff[0]`.
  - Each following `clk_rise` advances by one bit.
  - Bit k is presented after k rises, for k = 0..7.
- Reset mid-frame: `jp_data` returns to 1 on the next cycle. The frame is abandoned, and the next latch starts a fresh frame.

## Structure
- Shared package `jp_pkg`:
  - Button index constants `BTN_A`=0, `BTN_B`=1, `BTN_SELECT`=2, `BTN_START`=3, `BTN_UP`=4, `BTN_DOWN`=5, `BTN_LEFT`=6, `BTN_RIGHT`=7.
  - Frame length constant `JP_FRAME_BITS`=8.
  - These constants are shared with the console-side joypad controller.
- Sub-module `jp_sync_edge`:
  - Parameterised synchronizer plus rise/fall detector.
  - Instantiated twice, for latch and clk.
  - Reset value is 0 for all stages.

## Test plan
- **Basic frame:** `buttons`=8'b1000_0101, latch pulse then 8 clocks -> `jp_data` sequence 0,1,0,1,1,1,1,0. `poll_count`=1.
- **Overread:** 10 clocks after latch -> clocks 9 and 10 each give an `overread` pulse, and `jp_data`=0 for both.
- **Turbo:** `turbo_en`=2'b01, A held, `TURBO_DIV`=4, 12 polls -> first `jp_data` bit is 0,0,0,0, then 1,1,1,1, then 0,0,0,0.
- **Simultaneous/latched clock:**
  - A `clk_rise` coincident with `lat_fall` -> no shift; bit 0 is still presented.
  - Clocks while latch is high -> `sr` is unchanged from `eff`.
- **Reset mid-frame:** assert `rst` after 3 shifts -> `jp_data`=1 and `poll_count`=0. A following full frame reads correctly.
- **Wrap and loopback:**
  - 65536 polls -> `poll_count` wraps to 0.
  - Loopback with the console joypad controller returns `buttons` exactly, for random values.
